// File: rtl/instruction_fetch_pkg.sv
// Shared fetch-stage definitions: FSM state encoding and the default
// address/instruction widths also used by program_counter and decode.
package instruction_fetch_pkg;

  localparam int unsigned IF_ADDR_WIDTH  = 16;
  localparam int unsigned IF_INSTR_WIDTH = 32;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_DRAIN = 2'd2,
    ST_HOLD  = 2'd3
  } fetch_state_e;

endpackage

// File: rtl/instruction_fetch_ifid_reg.sv
// IF/ID pipeline register: clear drops the valid bit, load captures a new
// instruction and its address, otherwise every field holds.
module ifid_reg
  import instruction_fetch_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH  = IF_ADDR_WIDTH,
  parameter int unsigned INSTR_WIDTH = IF_INSTR_WIDTH
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   clear,
  input  logic                   load,
  input  logic [INSTR_WIDTH-1:0] load_instr,
  input  logic [ADDR_WIDTH-1:0]  load_pc,
  output logic                   valid,
  output logic [INSTR_WIDTH-1:0] instr,
  output logic [ADDR_WIDTH-1:0]  pc,
  output logic [ADDR_WIDTH-1:0]  pc_plus1
);

  logic                   valid_q, valid_d;
  logic [INSTR_WIDTH-1:0] instr_q, instr_d;
  logic [ADDR_WIDTH-1:0]  pc_q, pc_d;
  logic [ADDR_WIDTH-1:0]  pc_plus1_q, pc_plus1_d;

  always_comb begin
    valid_d    = valid_q;
    instr_d    = instr_q;
    pc_d       = pc_q;
    pc_plus1_d = pc_plus1_q;
    if (clear) begin
      valid_d = 1'b0;
    end else if (load) begin
      valid_d    = 1'b1;
      instr_d    = load_instr;
      pc_d       = load_pc;
      pc_plus1_d = load_pc + ADDR_WIDTH'(1);
    end else begin
      valid_d = valid_q;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      valid_q    <= 1'b0;
      instr_q    <= '0;
      pc_q       <= '0;
      pc_plus1_q <= ADDR_WIDTH'(1);
    end else begin
      valid_q    <= valid_d;
      instr_q    <= instr_d;
      pc_q       <= pc_d;
      pc_plus1_q <= pc_plus1_d;
    end
  end

  assign valid    = valid_q;
  assign instr    = instr_q;
  assign pc       = pc_q;
  assign pc_plus1 = pc_plus1_q;

endmodule

// File: rtl/instruction_fetch.sv
// Fetch stage: PC update, imem req/ack handshake, redirect drain and IF/ID load.
// Define IFETCH_SKID_EN to capture stalled responses in a 1-entry skid buffer.
module instruction_fetch
  import instruction_fetch_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH  = IF_ADDR_WIDTH,
  parameter int unsigned INSTR_WIDTH = IF_INSTR_WIDTH
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic [ADDR_WIDTH-1:0]  pc_cur,
  output logic [ADDR_WIDTH-1:0]  pc_next,
  output logic                   pc_write,
  output logic                   imem_req,
  output logic [ADDR_WIDTH-1:0]  imem_addr,
  input  logic                   imem_ack,
  input  logic [INSTR_WIDTH-1:0] imem_rdata,
  input  logic                   stall,
  input  logic                   flush,
  input  logic                   branch_taken,
  input  logic [ADDR_WIDTH-1:0]  branch_target,
  output logic                   ifid_valid,
  output logic [INSTR_WIDTH-1:0] ifid_instr,
  output logic [ADDR_WIDTH-1:0]  ifid_pc,
  output logic [ADDR_WIDTH-1:0]  ifid_pc_plus1
);

  fetch_state_e           state_q, state_d;
  logic [ADDR_WIDTH-1:0]  req_addr_q, req_addr_d;
  logic [ADDR_WIDTH-1:0]  imem_addr_q, imem_addr_d;
  logic                   imem_req_q, imem_req_d;
  logic [ADDR_WIDTH-1:0]  seq_addr_s;
  logic                   ifid_load_s, ifid_clear_s;
  logic [INSTR_WIDTH-1:0] ifid_load_instr_s;
  logic [ADDR_WIDTH-1:0]  ifid_load_pc_s;
`ifdef IFETCH_SKID_EN
  logic [INSTR_WIDTH-1:0] skid_instr_q, skid_instr_d;
  logic [ADDR_WIDTH-1:0]  skid_pc_q, skid_pc_d;
`endif

  assign seq_addr_s = req_addr_q + ADDR_WIDTH'(1);

  // req_addr is the next address to fetch; imem_addr_q keeps the outstanding one in DRAIN.
  always_comb begin
    state_d           = state_q;
    req_addr_d        = req_addr_q;
    imem_addr_d       = imem_addr_q;
    imem_req_d        = imem_req_q;
    pc_write          = 1'b0;
    pc_next           = req_addr_q;
    ifid_load_s       = 1'b0;
    ifid_load_instr_s = imem_rdata;
    ifid_load_pc_s    = req_addr_q;
`ifdef IFETCH_SKID_EN
    skid_instr_d      = skid_instr_q;
    skid_pc_d         = skid_pc_q;
`endif
    if (branch_taken) begin
      pc_write   = 1'b1;
      pc_next    = branch_target;
      req_addr_d = branch_target;
      case (state_q)
        ST_FETCH, ST_DRAIN: begin
          if (imem_ack) begin
            state_d     = ST_FETCH;
            imem_addr_d = branch_target;
          end else begin
            state_d     = ST_DRAIN;
          end
        end
        default: begin
          state_d     = ST_FETCH;
          imem_req_d  = 1'b1;
          imem_addr_d = branch_target;
        end
      endcase
    end else begin
      case (state_q)
        ST_IDLE: begin
          state_d     = ST_FETCH;
          req_addr_d  = pc_cur;
          imem_addr_d = pc_cur;
          imem_req_d  = 1'b1;
        end
        ST_FETCH: begin
          if (imem_ack && !flush && !stall) begin
            ifid_load_s = 1'b1;
            pc_write    = 1'b1;
            pc_next     = seq_addr_s;
            req_addr_d  = seq_addr_s;
            imem_addr_d = seq_addr_s;
`ifdef IFETCH_SKID_EN
          end else if (imem_ack && !flush) begin
            skid_instr_d = imem_rdata;
            skid_pc_d    = req_addr_q;
            pc_write     = 1'b1;
            pc_next      = seq_addr_s;
            req_addr_d   = seq_addr_s;
            imem_addr_d  = seq_addr_s;
            imem_req_d   = 1'b0;
            state_d      = ST_HOLD;
`endif
          end else begin
            // No ack, or a flushed/stalled ack: the same address is requested again.
            state_d = ST_FETCH;
          end
        end
        ST_DRAIN: begin
          if (imem_ack) begin
            state_d     = ST_FETCH;
            imem_addr_d = req_addr_q;
          end else begin
            state_d     = ST_DRAIN;
          end
        end
`ifdef IFETCH_SKID_EN
        ST_HOLD: begin
          if (flush) begin
            state_d     = ST_FETCH;
            imem_req_d  = 1'b1;
            imem_addr_d = req_addr_q;
          end else if (stall) begin
            state_d     = ST_HOLD;
          end else begin
            ifid_load_s       = 1'b1;
            ifid_load_instr_s = skid_instr_q;
            ifid_load_pc_s    = skid_pc_q;
            state_d           = ST_FETCH;
            imem_req_d        = 1'b1;
            imem_addr_d       = req_addr_q;
          end
        end
`endif
        default: begin
          state_d    = ST_IDLE;
          imem_req_d = 1'b0;
        end
      endcase
    end
    // An unstalled cycle with nothing to load leaves a bubble in IF/ID.
    ifid_clear_s = branch_taken | flush | (!stall & !ifid_load_s);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= ST_IDLE;
      req_addr_q  <= '0;
      imem_addr_q <= '0;
      imem_req_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      req_addr_q  <= req_addr_d;
      imem_addr_q <= imem_addr_d;
      imem_req_q  <= imem_req_d;
    end
  end

`ifdef IFETCH_SKID_EN
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      skid_instr_q <= '0;
      skid_pc_q    <= '0;
    end else begin
      skid_instr_q <= skid_instr_d;
      skid_pc_q    <= skid_pc_d;
    end
  end
`endif

  assign imem_req  = imem_req_q;
  assign imem_addr = imem_addr_q;

  ifid_reg #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .INSTR_WIDTH(INSTR_WIDTH)
  ) u_ifid_reg (
    .clk       (clk),
    .reset_n   (reset_n),
    .clear     (ifid_clear_s),
    .load      (ifid_load_s),
    .load_instr(ifid_load_instr_s),
    .load_pc   (ifid_load_pc_s),
    .valid     (ifid_valid),
    .instr     (ifid_instr),
    .pc        (ifid_pc),
    .pc_plus1  (ifid_pc_plus1)
  );

endmodule

// File: doc/instruction_fetch.md
# instruction_fetch

Fetch stage between the program counter register and the IF/ID boundary of the pipelined datapath. It takes the current PC, runs a req/ack handshake with instruction memory, and registers each returned instruction into the IF/ID pipeline register. It also drives the program counter's next-value and write-enable inputs, selecting between sequential increment and branch redirect. Stall, flush and in-flight-fetch kill are all handled here.

## Interface
- ADDR_WIDTH, 16: PC / instruction-memory word-address width
- INSTR_WIDTH, 32: instruction width
- clk  in  1  sole clock, rising edge
- reset_n  in  1  asynchronous, active-low reset
- pc_cur  in  ADDR_WIDTH  current PC from the program counter register
- pc_next  out  ADDR_WIDTH  next PC value to the program counter
- pc_write  out  1  program counter write enable
- imem_req  out  1  fetch request, held until acked
- imem_addr  out  ADDR_WIDTH  fetch word address, stable while imem_req=1
- imem_ack  in  1  response valid; imem_rdata sampled this cycle
- imem_rdata  in  INSTR_WIDTH  returned instruction
- stall  in  1  decode cannot accept; hold IF/ID
- flush  in  1  invalidate IF/ID
- branch_taken  in  1  one-cycle redirect pulse
- branch_target  in  ADDR_WIDTH  redirect address, valid with branch_taken
- ifid_valid  out  1  IF/ID holds a live instruction
- ifid_instr  out  INSTR_WIDTH  fetched instruction
- ifid_pc  out  ADDR_WIDTH  address of ifid_instr
- ifid_pc_plus1  out  ADDR_WIDTH  ifid_pc+1, modulo 2^ADDR_WIDTH

## Operation
- Word addressed; increment is +1, wraps from all-ones to 0 with no flag.
- FSM states:
  - IDLE: first cycle after reset release; no request; goes to FETCH, latching req_addr=pc_cur.
  - FETCH: imem_req=1, imem_addr=req_addr.
  - DRAIN: request still outstanding after a redirect; its response is discarded.
  - HOLD: only with skid buffer.
- FETCH with imem_ack and no stall:
  - load IF/ID with imem_rdata and req_addr; set ifid_valid=1
  - pc_write=1, pc_next=req_addr+1; req_addr<=req_addr+1; stay in FETCH
- FETCH with imem_ack and stall: response dropped; pc_write=0; same address re-requested next cycle.
- branch_taken, any state: pc_write=1, pc_next=branch_target, req_addr<=branch_target, ifid_valid<=0 (the wrong-path slot is squashed).
  - If in FETCH without ack this cycle: go to DRAIN.
  - If in FETCH with ack this cycle: the response is discarded.
- DRAIN: imem_req stays 1 with the old address; on ack, data is discarded and the FSM goes to FETCH with the redirect address.
- Priority: reset_n > branch_taken > flush > stall > normal advance.
- flush: ifid_valid<=0 at the next edge; the PC is unaffected.
- stall without flush: all IF/ID fields hold.
- pc_write is combinational from state and inputs; it is never 1 in IDLE unless branch_taken.

## Timing
- Reset values:
  - outputs: imem_req=0, imem_addr=0, pc_write=0, pc_next=0, ifid_valid=0, ifid_instr=0, ifid_pc=0, ifid_pc_plus1=1
  - internal: req_addr=0, state=IDLE
- reset_n asserted mid-fetch: state returns to IDLE immediately and any outstanding ack is ignored. The memory is reset on the same reset_n.
- Throughput: with imem_ack in the same cycle as imem_req, one instruction per cycle.
- Fetch latency: IF/ID is updated at the edge ending the ack cycle.
- Redirect penalty: ≥1 bubble; +N cycles while DRAIN waits for an outstanding ack.
- imem_addr changes only on an edge where the request completes or the FSM enters FETCH.

## Configuration
- IFETCH_SKID_EN defined:
  - An ack during stall is captured in a 1-entry skid buffer (instr, pc), with pc_write=1 to advance, and the FSM goes to HOLD with imem_req=0.
  - The first cycle with stall=0 in HOLD loads IF/ID from the skid buffer and returns to FETCH.
  - branch_taken or flush in HOLD empties the skid buffer.
- IFETCH_SKID_EN undefined: no HOLD state and no skid buffer; a stalled ack is dropped and refetched as above.

## Structure
- Shared package holds:
  - the FSM state encoding (IDLE, FETCH, DRAIN, HOLD)
  - the default ADDR_WIDTH / INSTR_WIDTH constants shared with program_counter and decode
- One sub-module: ifid_reg, the IF/ID pipeline register with load/hold/clear, instantiated once.

## Test plan
- Release reset, memory acks same-cycle returning 0x1000+addr → IF/ID shows addr 0,1,2,3 on consecutive cycles; pc_write=1 each fetch cycle.
- Memory with 2-cycle ack latency → imem_addr is stable across wait cycles; ifid_valid pulses once per 3 cycles.
- branch_taken with target 0x0040 while a fetch is outstanding → DRAIN; the late response is discarded; next ifid_pc=0x0040.
- stall for 3 cycles during acks:
  - IFETCH_SKID_EN undefined: the instruction is refetched and the PC does not move.
  - IFETCH_SKID_EN defined: PC advances once, the buffered instruction appears when stall falls, and no memory request is issued while stalled.
- Sequential fetch from pc_cur=0xFFFF → pc_next=0x0000, ifid_pc_plus1=0x0000.
- reset_n asserted mid-DRAIN with a pending ack → all outputs return to reset values immediately; the ack arriving after release is ignored.
